// File: rtl/alu_op_sequencer.sv
// Multi-cycle command controller for the 8x32 register file / ALU / write-back mux datapath.
// Runs one ALU or load-immediate command at a time and drives every RF, ALU and mux control pin.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NREGS   = 8,
    parameter int MAX_OP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_load,
    input  logic [3:0]         cmd_op,
    input  logic [RADDR_W-1:0] cmd_rd,
    input  logic [RADDR_W-1:0] cmd_rs1,
    input  logic [RADDR_W-1:0] cmd_rs2,
    input  logic [3:0]         cmd_shamt,
    input  logic               cmd_sign,
    input  logic [DATA_W-1:0]  cmd_imm,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [RADDR_W-1:0] rf_rr1,
    output logic [RADDR_W-1:0] rf_rr2,
    output logic [RADDR_W-1:0] rf_wr,
    output logic               rf_we,
    output logic [3:0]         alu_op,
    output logic [3:0]         alu_shamount,
    output logic               alu_sign,
    output logic               mux_ctrl,
    output logic [DATA_W-1:0]  wdata_ext,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  done_result,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, LOADWB} state_t;

    state_t state, state_next;
    logic   accept;
    logic   illegal;

    always_comb begin
        accept  = cmd_valid && (state == IDLE);
        illegal = (int'(cmd_rd) >= NREGS) ||
                  (!cmd_load && ((int'(cmd_op) > MAX_OP) ||
                                 (int'(cmd_rs1) >= NREGS) ||
                                 (int'(cmd_rs2) >= NREGS)));

        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        rf_we      = 1'b0;
        mux_ctrl   = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = !rst;
                if (accept && !illegal) begin
                    state_next = cmd_load ? LOADWB : READ;
                end
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            // Gating with rst keeps the write strobe low even in the delta before the async reset lands.
            WB: begin
                rf_we      = !rst;
                done       = !rst;
                mux_ctrl   = 1'b1;
                state_next = IDLE;
            end
            LOADWB: begin
                rf_we      = !rst;
                done       = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The command latch doubles as the output registers, so rr/op/shamt/sign stay put in IDLE and through WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_rr1       <= '0;
            rf_rr2       <= '0;
            rf_wr        <= '0;
            alu_op       <= '0;
            alu_shamount <= '0;
            alu_sign     <= 1'b0;
            wdata_ext    <= '0;
            done_result  <= '0;
            err          <= 1'b0;
        end else begin
            err <= accept && illegal;
            if (accept && !illegal) begin
                rf_wr <= cmd_rd;
                if (cmd_load) begin
                    wdata_ext   <= cmd_imm;
                    done_result <= cmd_imm;
                end else begin
                    rf_rr1       <= cmd_rs1;
                    rf_rr2       <= cmd_rs2;
                    alu_op       <= cmd_op;
                    alu_shamount <= cmd_shamt;
                    alu_sign     <= cmd_sign;
                end
            end
            if (state == EXEC) begin
                done_result <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural RF/ALU harness around the controller plus
// a command-level reference register file that predicts every write-back value and its timing.
module tb_alu_op_sequencer;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS   = 8;
    localparam int MAX_OP  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_load = 1'b0;
    logic [3:0]         cmd_op = '0;
    logic [RADDR_W-1:0] cmd_rd = '0;
    logic [RADDR_W-1:0] cmd_rs1 = '0;
    logic [RADDR_W-1:0] cmd_rs2 = '0;
    logic [3:0]         cmd_shamt = '0;
    logic               cmd_sign = 1'b0;
    logic [DATA_W-1:0]  cmd_imm = '0;
    logic [DATA_W-1:0]  alu_result;
    logic [RADDR_W-1:0] rf_rr1, rf_rr2, rf_wr;
    logic               rf_we;
    logic [3:0]         alu_op, alu_shamount;
    logic               alu_sign, mux_ctrl;
    logic [DATA_W-1:0]  wdata_ext;
    logic               busy, done;
    logic [DATA_W-1:0]  done_result;
    logic               err;

    alu_op_sequencer #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W),
        .NREGS  (NREGS),
        .MAX_OP (MAX_OP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_shamt   (cmd_shamt),
        .cmd_sign    (cmd_sign),
        .cmd_imm     (cmd_imm),
        .alu_result  (alu_result),
        .rf_rr1      (rf_rr1),
        .rf_rr2      (rf_rr2),
        .rf_wr       (rf_wr),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_shamount(alu_shamount),
        .alu_sign    (alu_sign),
        .mux_ctrl    (mux_ctrl),
        .wdata_ext   (wdata_ext),
        .busy        (busy),
        .done        (done),
        .done_result (done_result),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural ALU used both by the harness and to predict results.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sh, input logic sg);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return $signed(a) >>> sh;
            4'd7:    return a >> sh;
            4'd8:    return {31'b0, ($signed(a) < $signed(b)) ^ sg};
            default: return '0;
        endcase
    endfunction

    // Datapath harness: registered-read RF plus mux, driven purely by the DUT control pins.
    logic [31:0] rf [NREGS] = '{default: '0};
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_we) rf[rf_wr[2:0]] <= mux_ctrl ? alu_result : wdata_ext;
        rd1 <= rf[rf_rr1[2:0]];
        rd2 <= rf[rf_rr2[2:0]];
    end
    always_comb alu_result = alu_f(alu_op, rd1, rd2, alu_shamount, alu_sign);

    logic [31:0] done_q[$];
    always @(negedge clk) if (done) done_q.push_back(done_result);

    logic [31:0] ref_rf [NREGS] = '{default: '0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_cmd(input bit load, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [3:0] sh, input bit sg, input logic [31:0] imm);
        bit          bad;
        int          lat;
        logic [31:0] expv;
        bad  = (rd >= NREGS) || (!load && (op > MAX_OP || rs1 >= NREGS || rs2 >= NREGS));
        expv = '0;
        if (!bad) expv = load ? imm : alu_f(op, ref_rf[rs1[2:0]], ref_rf[rs2[2:0]], sh, sg);
        #1;
        check("ready_idle", cmd_ready, 1);
        cmd_load = load; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_shamt = sh; cmd_sign = sg; cmd_imm = imm; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (bad) begin
            check("err_pulse", err, 1);
            check("err_no_we", rf_we, 0);
            check("err_no_done", done, 0);
            check("err_ready", cmd_ready, 1);
            @(negedge clk);
            check("err_clear", err, 0);
            check("err_no_we2", rf_we, 0);
        end else begin
            lat = load ? 1 : 3;
            for (int c = 1; c <= lat; c++) begin
                if (c > 1) @(negedge clk);
                check("busy", busy, 1);
                check("ready_low", cmd_ready, 0);
                check("we_timing", rf_we, 32'(c == lat));
                check("done_timing", done, 32'(c == lat));
                check("no_err", err, 0);
                if (c == lat) begin
                    check("mux_ctrl", mux_ctrl, 32'(!load));
                    check("rf_wr", rf_wr, rd);
                    check("done_result", done_result, expv);
                    if (load) check("wdata_ext", wdata_ext, imm);
                end
            end
            @(negedge clk);
            check("we_after", rf_we, 0);
            check("idle_after", busy, 0);
            check("rf_written", rf[rd[2:0]], expv);
            check("result_held", done_result, expv);
            ref_rf[rd[2:0]] = expv;
        end
    endtask

    initial begin
        int          base;
        int          acc [3];
        logic [31:0] bexp [3];
        logic [3:0]  bop  [3];
        logic [4:0]  brd  [3];
        logic [4:0]  brs1 [3];
        logic [4:0]  brs2 [3];
        bit          got;
        logic [31:0] keep;

        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", done_result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_cmd(1, 4'd0, 5'd1, 5'd0, 5'd0, 4'd0, 0, 32'hFFFF_FFCB);
        check("load_m53", done_result, 32'hFFFF_FFCB);
        run_cmd(1, 4'd0, 5'd2, 5'd0, 5'd0, 4'd0, 0, 32'd3);
        check("load_3", done_result, 32'h0000_0003);
        run_cmd(0, 4'd0, 5'd3, 5'd1, 5'd2, 4'd0, 0, 32'd0);
        check("add_lit", done_result, 32'hFFFF_FFCE);
        run_cmd(1, 4'd0, 5'd1, 5'd0, 5'd0, 4'd0, 0, 32'hFFFF_FFFB);
        run_cmd(0, 4'd6, 5'd4, 5'd1, 5'd0, 4'd2, 0, 32'd0);
        check("sra_lit", done_result, 32'hFFFF_FFFE);
        run_cmd(1, 4'd0, 5'd1, 5'd0, 5'd0, 4'd0, 0, 32'd5);
        run_cmd(0, 4'd1, 5'd5, 5'd1, 5'd2, 4'd0, 0, 32'd0);
        check("sub_lit", done_result, 32'h0000_0002);

        run_cmd(0, 4'd9, 5'd1, 5'd1, 5'd2, 4'd0, 0, 32'd0);
        run_cmd(1, 4'd0, 5'd9, 5'd0, 5'd0, 4'd0, 0, 32'hDEAD_BEEF);
        run_cmd(0, 4'd0, 5'd6, 5'd1, 5'd12, 4'd0, 0, 32'd0);
        check("illegal_no_write", rf[1], 32'd5);
        check("illegal_result_held", done_result, 32'd2);

        // Abort in EXEC.
        base = done_q.size();
        keep = rf[6];
        #1;
        cmd_load = 0; cmd_op = 4'd0; cmd_rd = 5'd6; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_we", rf_we, 0);
        check("abort_busy", busy, 0);
        check("abort_result", done_result, 0);
        check("abort_ready_rst", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_we", rf_we, 0);
        end
        check("abort_rf", rf[6], keep);
        check("abort_no_done", done_q.size() - base, 0);

        // Abort in WB.
        keep = rf[7];
        #1;
        cmd_load = 0; cmd_op = 4'd0; cmd_rd = 5'd7; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        check("wb_reached", rf_we, 1);
        rst = 1'b1;
        #1;
        check("wb_abort_we", rf_we, 0);
        check("wb_abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("wb_abort_rf", rf[7], keep);

        // Back-to-back with cmd_valid held high; each command depends on the previous one.
        bop[0] = 4'd0; brd[0] = 5'd7; brs1[0] = 5'd1; brs2[0] = 5'd2;
        bop[1] = 4'd1; brd[1] = 5'd6; brs1[1] = 5'd7; brs2[1] = 5'd5;
        bop[2] = 4'd4; brd[2] = 5'd0; brs1[2] = 5'd6; brs2[2] = 5'd7;
        base = done_q.size();
        #1;
        for (int k = 0; k < 3; k++) begin
            cmd_load = 0; cmd_op = bop[k]; cmd_rd = brd[k]; cmd_rs1 = brs1[k]; cmd_rs2 = brs2[k];
            cmd_shamt = '0; cmd_sign = 0; cmd_valid = 1'b1;
            got = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                if (cmd_ready) got = 1;
                else @(negedge clk);
            end
            check("b2b_accept", 32'(got), 1);
            acc[k]  = cyc;
            bexp[k] = alu_f(bop[k], ref_rf[brs1[k][2:0]], ref_rf[brs2[k][2:0]], 4'd0, 1'b0);
            ref_rf[brd[k][2:0]] = bexp[k];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_gap1", acc[1] - acc[0], 4);
        check("b2b_gap2", acc[2] - acc[1], 4);
        check("b2b_count", done_q.size() - base, 3);
        for (int k = 0; k < 3; k++) begin
            if (done_q.size() > base + k) check("b2b_order", done_q[base + k], bexp[k]);
            else check("b2b_missing", 0, bexp[k]);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [4:0] rd, r1, r2;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            rd = ($urandom_range(0, 12) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 12) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 12) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            run_cmd($urandom_range(0, 2) == 0, op, rd, r1, r2, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
